// File: rtl/rob_pkg.sv
// rob_pkg: shared sizing constants, the ROB entry record and a small
// one-hot helper used by the reorder buffer.
//
// Contents
//   ROB_DEPTH    number of ROB entries (power of 2, >= 4)
//   ROB_TAG_W    log2(ROB_DEPTH), width of a ROB tag
//   PREG_W       physical register index width
//   NUM_PREGS    number of physical registers (width of the free vector)
//   rob_entry_t  one circular-buffer slot {valid, done, has_rd, rd, old_rd}
//   preg_onehot  physical register index -> one-hot free-vector bit
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = 4;
  localparam int PREG_W    = 6;
  localparam int NUM_PREGS = 64;

  typedef struct packed {
    logic              valid;   // slot holds a live instruction
    logic              done;    // execute has reported completion
    logic              has_rd;  // instruction writes a destination register
    logic [PREG_W-1:0] rd;      // newly allocated physical destination
    logic [PREG_W-1:0] old_rd;  // mapping released when this entry retires
  } rob_entry_t;

  function automatic logic [NUM_PREGS-1:0] preg_onehot(input logic [PREG_W-1:0] preg);
    logic [NUM_PREGS-1:0] vec;
    vec       = '0;
    vec[preg] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit stage sitting directly behind rename.
// Accepts up to two renamed instructions per cycle, records completions from
// two execute ports, retires up to two completed instructions per cycle in
// program order and hands each retired old_rd mapping back to rename's free
// pool as a one-cycle multi-hot pulse.
//
// Ports
//   clk                          clock, all state updates on posedge
//   rst_n                        synchronous reset, active low
//   alloc_valid_1/_2             allocation request, slot 1 older than slot 2
//   alloc_has_rd_1/_2            instruction writes a destination register
//   alloc_rd_1/_2                new physical destination from rename
//   alloc_old_rd_1/_2            previous physical mapping of the arch rd
//   alloc_ready                  at least two free entries (registered count)
//   alloc_tag_1/_2               ROB tags that the current requests receive
//   cmpl_valid_1/_2, cmpl_tag_*  completion reports from execute
//   free_regs                    registered pulse, bit p set = preg p freed
//   retire_cnt                   registered number of retired instructions
//   rob_count                    occupied entries
//   rob_empty                    no occupied entries
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = ROB_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 alloc_valid_1,
  input  logic                 alloc_has_rd_1,
  input  logic [PREG_W-1:0]    alloc_rd_1,
  input  logic [PREG_W-1:0]    alloc_old_rd_1,
  input  logic                 alloc_valid_2,
  input  logic                 alloc_has_rd_2,
  input  logic [PREG_W-1:0]    alloc_rd_2,
  input  logic [PREG_W-1:0]    alloc_old_rd_2,
  output logic                 alloc_ready,
  output logic [TAG_W-1:0]     alloc_tag_1,
  output logic [TAG_W-1:0]     alloc_tag_2,

  input  logic                 cmpl_valid_1,
  input  logic [TAG_W-1:0]     cmpl_tag_1,
  input  logic                 cmpl_valid_2,
  input  logic [TAG_W-1:0]     cmpl_tag_2,

  output logic [NUM_PREGS-1:0] free_regs,
  output logic [1:0]           retire_cnt,
  output logic [TAG_W:0]       rob_count,
  output logic                 rob_empty
);

  localparam logic [TAG_W-1:0] TAG_ONE     = TAG_W'(1);
  localparam logic [TAG_W:0]   READY_LIMIT = (TAG_W+1)'(DEPTH - 2);

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  rob_entry_t           entries_q [DEPTH];
  rob_entry_t           entries_d [DEPTH];
  logic [TAG_W-1:0]     head_q,  head_d;
  logic [TAG_W-1:0]     tail_q,  tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic [NUM_PREGS-1:0] free_regs_q,  free_regs_d;
  logic [1:0]           retire_cnt_q, retire_cnt_d;

  // --------------------------------------------------------------------
  // Allocation side
  // --------------------------------------------------------------------
  logic       accept_1;
  logic       accept_2;
  logic [1:0] n_alloc;

  // Readiness looks only at the registered count, so a retire in the same
  // cycle never opens space for an allocation until the next cycle.
  assign alloc_ready = (count_q <= READY_LIMIT);
  assign alloc_tag_1 = tail_q;
  // A lone slot-2 request takes the tail entry itself.
  assign alloc_tag_2 = alloc_valid_1 ? (tail_q + TAG_ONE) : tail_q;

  assign accept_1 = alloc_ready & alloc_valid_1;
  assign accept_2 = alloc_ready & alloc_valid_2;
  assign n_alloc  = {1'b0, accept_1} + {1'b0, accept_2};

  // --------------------------------------------------------------------
  // Retire select, evaluated purely from registered state
  // --------------------------------------------------------------------
  logic [TAG_W-1:0] head_p1;
  logic             ret_1;
  logic             ret_2;

  assign head_p1 = head_q + TAG_ONE;

  always_comb begin
    ret_1        = entries_q[head_q].valid & entries_q[head_q].done;
    // The second retire slot is only usable behind a retiring head, which
    // keeps retirement strictly in program order.
    ret_2        = ret_1 & entries_q[head_p1].valid & entries_q[head_p1].done;
    free_regs_d  = '0;
    if (ret_1 && entries_q[head_q].has_rd) begin
      free_regs_d = free_regs_d | preg_onehot(entries_q[head_q].old_rd);
    end
    if (ret_2 && entries_q[head_p1].has_rd) begin
      free_regs_d = free_regs_d | preg_onehot(entries_q[head_p1].old_rd);
    end
    retire_cnt_d = {1'b0, ret_1} + {1'b0, ret_2};
  end

  // --------------------------------------------------------------------
  // Pointer and occupancy update
  // --------------------------------------------------------------------
  always_comb begin
    head_d  = head_q + TAG_W'(retire_cnt_d);
    tail_d  = tail_q + TAG_W'(n_alloc);
    count_d = count_q + (TAG_W+1)'(n_alloc) - (TAG_W+1)'(retire_cnt_d);
  end

  // --------------------------------------------------------------------
  // Entry next-state
  //   Completion only marks live entries. Retiring entries are already
  //   done, so clearing them after the completion update loses nothing.
  //   Allocation targets free slots, which never overlap retiring ones.
  // --------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];

      if (entries_q[i].valid &&
          ((cmpl_valid_1 && (cmpl_tag_1 == TAG_W'(i))) ||
           (cmpl_valid_2 && (cmpl_tag_2 == TAG_W'(i))))) begin
        entries_d[i].done = 1'b1;
      end

      if ((ret_1 && (head_q  == TAG_W'(i))) ||
          (ret_2 && (head_p1 == TAG_W'(i)))) begin
        entries_d[i] = '0;
      end

      if (accept_1 && (alloc_tag_1 == TAG_W'(i))) begin
        entries_d[i].valid  = 1'b1;
        entries_d[i].done   = 1'b0;
        entries_d[i].has_rd = alloc_has_rd_1;
        entries_d[i].rd     = alloc_rd_1;
        entries_d[i].old_rd = alloc_old_rd_1;
      end

      if (accept_2 && (alloc_tag_2 == TAG_W'(i))) begin
        entries_d[i].valid  = 1'b1;
        entries_d[i].done   = 1'b0;
        entries_d[i].has_rd = alloc_has_rd_2;
        entries_d[i].rd     = alloc_rd_2;
        entries_d[i].old_rd = alloc_old_rd_2;
      end
    end
  end

  // --------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      free_regs_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      free_regs_q  <= free_regs_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign free_regs  = free_regs_q;
  assign retire_cnt = retire_cnt_q;
  assign rob_count  = count_q;
  assign rob_empty  = (count_q == '0);

  // --------------------------------------------------------------------
  // Upstream sanity: rename never hands out a destination equal to the
  // mapping it replaces; freeing such a register would corrupt the pool.
  // --------------------------------------------------------------------
  a_ret1_distinct : assert property (@(posedge clk) disable iff (!rst_n)
    (ret_1 && entries_q[head_q].has_rd)
      |-> (entries_q[head_q].rd != entries_q[head_q].old_rd));

  a_ret2_distinct : assert property (@(posedge clk) disable iff (!rst_n)
    (ret_2 && entries_q[head_p1].has_rd)
      |-> (entries_q[head_p1].rd != entries_q[head_p1].old_rd));

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios followed by randomized traffic,
// all checked against a queue-based program-order model of the ROB.
module tb_reorder_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alloc_valid_1, alloc_has_rd_1;
  logic [5:0]  alloc_rd_1, alloc_old_rd_1;
  logic        alloc_valid_2, alloc_has_rd_2;
  logic [5:0]  alloc_rd_2, alloc_old_rd_2;
  logic        alloc_ready;
  logic [3:0]  alloc_tag_1, alloc_tag_2;
  logic        cmpl_valid_1, cmpl_valid_2;
  logic [3:0]  cmpl_tag_1, cmpl_tag_2;
  logic [63:0] free_regs;
  logic [1:0]  retire_cnt;
  logic [4:0]  rob_count;
  logic        rob_empty;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid_1  (alloc_valid_1),
    .alloc_has_rd_1 (alloc_has_rd_1),
    .alloc_rd_1     (alloc_rd_1),
    .alloc_old_rd_1 (alloc_old_rd_1),
    .alloc_valid_2  (alloc_valid_2),
    .alloc_has_rd_2 (alloc_has_rd_2),
    .alloc_rd_2     (alloc_rd_2),
    .alloc_old_rd_2 (alloc_old_rd_2),
    .alloc_ready    (alloc_ready),
    .alloc_tag_1    (alloc_tag_1),
    .alloc_tag_2    (alloc_tag_2),
    .cmpl_valid_1   (cmpl_valid_1),
    .cmpl_tag_1     (cmpl_tag_1),
    .cmpl_valid_2   (cmpl_valid_2),
    .cmpl_tag_2     (cmpl_tag_2),
    .free_regs      (free_regs),
    .retire_cnt     (retire_cnt),
    .rob_count      (rob_count),
    .rob_empty      (rob_empty)
  );

  // ------------------------------------------------------------------
  // Reference model: the ROB as a program-ordered queue of instructions.
  // ------------------------------------------------------------------
  typedef struct {
    logic [3:0] tag;
    logic       has_rd;
    logic [5:0] old_rd;
    logic       done;
  } minstr_t;

  minstr_t     mq[$];
  logic [3:0]  m_tail;
  logic [63:0] m_free;
  logic [1:0]  m_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    int          nret;
    logic [63:0] fv;
    bit          ready;
    if (!rst_n) begin
      mq.delete();
      m_tail = '0;
      m_free = '0;
      m_cnt  = '0;
    end else begin
      nret = 0;
      fv   = '0;
      if (mq.size() > 0 && mq[0].done) begin
        nret = 1;
        if (mq.size() > 1 && mq[1].done) nret = 2;
      end
      for (int k = 0; k < nret; k++) begin
        if (mq[k].has_rd) fv[mq[k].old_rd] = 1'b1;
      end
      m_free = fv;
      m_cnt  = 2'(nret);
      ready  = (mq.size() <= DEPTH - 2);
      for (int k = 0; k < nret; k++) begin
        $display("[%0t] retire tag=%0d has_rd=%0d old_rd=%0d", $time,
                 mq[0].tag, mq[0].has_rd, mq[0].old_rd);
        void'(mq.pop_front());
      end
      foreach (mq[j]) begin
        if ((cmpl_valid_1 && mq[j].tag == cmpl_tag_1) ||
            (cmpl_valid_2 && mq[j].tag == cmpl_tag_2)) mq[j].done = 1'b1;
      end
      if (ready && alloc_valid_1) begin
        mq.push_back('{tag: m_tail, has_rd: alloc_has_rd_1, old_rd: alloc_old_rd_1, done: 1'b0});
        m_tail = m_tail + 4'd1;
      end
      if (ready && alloc_valid_2) begin
        mq.push_back('{tag: m_tail, has_rd: alloc_has_rd_2, old_rd: alloc_old_rd_2, done: 1'b0});
        m_tail = m_tail + 4'd1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("rob_count",   rob_count,   64'(mq.size()));
    check_eq("rob_empty",   rob_empty,   64'(mq.size() == 0));
    check_eq("alloc_ready", alloc_ready, 64'(mq.size() <= DEPTH - 2));
    check_eq("alloc_tag_1", alloc_tag_1, m_tail);
    check_eq("alloc_tag_2", alloc_tag_2, 4'(m_tail + {3'b0, alloc_valid_1}));
    check_eq("free_regs",   free_regs,   m_free);
    check_eq("retire_cnt",  retire_cnt,  m_cnt);
  endtask

  // One clock: inputs are already driven (at the falling edge); the model
  // takes the same edge, and outputs are checked on the next falling edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    alloc_valid_1 = 0; alloc_has_rd_1 = 0; alloc_rd_1 = 0; alloc_old_rd_1 = 0;
    alloc_valid_2 = 0; alloc_has_rd_2 = 0; alloc_rd_2 = 0; alloc_old_rd_2 = 0;
    cmpl_valid_1  = 0; cmpl_tag_1 = 0; cmpl_valid_2 = 0; cmpl_tag_2 = 0;
  endtask

  task automatic set_alloc(input logic v1, input logic h1, input logic [5:0] rd1, input logic [5:0] o1,
                           input logic v2, input logic h2, input logic [5:0] rd2, input logic [5:0] o2);
    alloc_valid_1 = v1; alloc_has_rd_1 = h1; alloc_rd_1 = rd1; alloc_old_rd_1 = o1;
    alloc_valid_2 = v2; alloc_has_rd_2 = h2; alloc_rd_2 = rd2; alloc_old_rd_2 = o2;
  endtask

  task automatic set_cmpl(input logic v1, input logic [3:0] t1, input logic v2, input logic [3:0] t2);
    cmpl_valid_1 = v1; cmpl_tag_1 = t1; cmpl_valid_2 = v2; cmpl_tag_2 = t2;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Random alloc pair with rd always distinct from old_rd.
  task automatic rand_alloc();
    logic [5:0] o1, o2;
    o1 = 6'($urandom_range(0, 63));
    o2 = 6'($urandom_range(0, 63));
    set_alloc(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) != 0),
              o1 ^ 6'($urandom_range(1, 63)), o1,
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) != 0),
              o2 ^ 6'($urandom_range(1, 63)), o2);
  endtask

  task automatic rand_cmpl_port(output logic v, output logic [3:0] t);
    int sel;
    sel = $urandom_range(0, 9);
    v = 1'b0;
    t = 4'($urandom_range(0, 15));
    if (sel < 7 && mq.size() > 0) begin
      v = 1'b1;
      t = mq[$urandom_range(0, mq.size() - 1)].tag;
    end else if (sel == 7) begin
      v = 1'b1;  // arbitrary tag, possibly not live
    end
  endtask

  initial begin
    logic       v1, v2;
    logic [3:0] t1, t2;

    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);

    // Reset then idle.
    do_reset();
    tick();
    check_eq("idle_empty", rob_empty, 1);
    check_eq("idle_ready", alloc_ready, 1);
    check_eq("idle_free", free_regs, 0);
    check_eq("idle_cnt", retire_cnt, 0);

    // Pair alloc, completed together, retires as a pair.
    set_alloc(1, 1, 6'd32, 6'd5, 1, 1, 6'd33, 6'd7);
    tick();
    idle_inputs();
    set_cmpl(1, 4'd0, 1, 4'd1);
    tick();
    idle_inputs();
    tick();
    check_eq("pair_cnt", retire_cnt, 2);
    check_eq("pair_free", free_regs, 64'hA0);
    tick();
    check_eq("pair_free_pulse", free_regs, 0);
    check_eq("pair_cnt_pulse", retire_cnt, 0);

    // Out-of-order completion, in-order retire.
    do_reset();
    set_alloc(1, 1, 6'd40, 6'd1, 1, 1, 6'd41, 6'd2);
    tick();
    set_alloc(1, 1, 6'd42, 6'd3, 0, 0, 6'd0, 6'd0);
    tick();
    idle_inputs();
    set_cmpl(1, 4'd2, 0, 4'd0);
    tick();
    set_cmpl(1, 4'd1, 0, 4'd0);
    tick();
    idle_inputs();
    tick();
    check_eq("ooo_blocked_cnt", retire_cnt, 0);
    check_eq("ooo_blocked_count", rob_count, 3);
    set_cmpl(0, 4'd0, 1, 4'd0);
    tick();
    idle_inputs();
    tick();
    check_eq("ooo_first_cnt", retire_cnt, 2);
    check_eq("ooo_first_free", free_regs, 64'h6);
    tick();
    check_eq("ooo_second_cnt", retire_cnt, 1);
    check_eq("ooo_second_free", free_regs, 64'h8);
    tick();
    check_eq("ooo_done_cnt", retire_cnt, 0);

    // Fill to DEPTH-1, blocked alloc, retire reopens.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_alloc(1, 1, 6'(2 * i + 20), 6'(2 * i), 1, 1, 6'(2 * i + 21), 6'(2 * i + 1));
      tick();
    end
    set_alloc(1, 1, 6'd50, 6'd14, 0, 0, 6'd0, 6'd0);
    tick();
    check_eq("full_count", rob_count, 15);
    check_eq("full_ready", alloc_ready, 0);
    set_alloc(1, 1, 6'd51, 6'd15, 1, 1, 6'd52, 6'd16);
    tick();
    check_eq("full_tail_hold", alloc_tag_1, 15);
    check_eq("full_count_hold", rob_count, 15);
    idle_inputs();
    set_cmpl(1, 4'd0, 0, 4'd0);
    tick();
    idle_inputs();
    tick();
    check_eq("reopen_ready", alloc_ready, 1);
    check_eq("reopen_count", rob_count, 14);

    // 40 instructions through the buffer; tags wrap.
    do_reset();
    t1 = 0; t2 = 0; v1 = 0;
    for (int i = 0; i < 20; i++) begin
      logic [3:0] nt;
      nt = m_tail;
      rand_alloc();
      alloc_valid_1 = 1; alloc_valid_2 = 1;
      set_cmpl(v1, t1, v1, t2);
      tick();
      v1 = 1; t1 = nt; t2 = nt + 4'd1;
    end
    idle_inputs();
    set_cmpl(1, t1, 1, t2);
    tick();
    idle_inputs();
    repeat (3) tick();
    check_eq("wrap_empty", rob_empty, 1);

    // Store-like instruction frees nothing.
    set_alloc(1, 0, 6'd0, 6'd0, 0, 0, 6'd0, 6'd0);
    tick();
    idle_inputs();
    set_cmpl(1, alloc_tag_1 - 4'd1, 0, 4'd0);
    tick();
    idle_inputs();
    tick();
    check_eq("sw_cnt", retire_cnt, 1);
    check_eq("sw_free", free_regs, 0);

    // Reset with six live entries, two of them ready to retire.
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 1, 6'(i + 10), 6'(i + 30), 1, 1, 6'(i + 20), 6'(i + 40));
      tick();
    end
    idle_inputs();
    set_cmpl(1, m_tail - 4'd6, 1, m_tail - 4'd5);
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("rst_count", rob_count, 0);
    check_eq("rst_free", free_regs, 0);
    check_eq("rst_cnt", retire_cnt, 0);
    tick();
    check_eq("rst_free_after", free_regs, 0);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      rand_alloc();
      rand_cmpl_port(v1, t1);
      rand_cmpl_port(v2, t2);
      set_cmpl(v1, t1, v2, t2);
      tick();
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
